// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITE controller that owns the PC,
// with IMEM/DMEM req/ack handshakes, halt-on-self-jump and ack timeout. Option: SEQ_PERF_CNT_EN.
module stage_sequencer #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              MEM_TIMEOUT = 15
) (
   input  logic            CLK,
   input  logic            RSTN,
   input  logic            START,
   output logic            IMEM_REQ,
   output logic [XLEN-1:0] IMEM_ADDR,
   input  logic            IMEM_ACK,
   output logic            DMEM_REQ,
   input  logic            DMEM_ACK,
   input  logic            IS_MEM,
   input  logic [XLEN-1:0] NEXT_PC,
   output logic            FETCH_EN,
   output logic            DECODE_EN,
   output logic            EXEC_EN,
   output logic            WB_EN,
   output logic [XLEN-1:0] PC,
   output logic            RETIRE,
`ifdef SEQ_PERF_CNT_EN
   output logic [63:0]     CYCLE_CNT,
   output logic [63:0]     INSTRET_CNT,
`endif
   output logic            HALTED,
   output logic            FAULT
);

   localparam int               CNT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITE, S_HALT, S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   npc_q;
   logic              halt_q;
   logic [CNT_W-1:0]  wait_q;
   logic              wait_clr, wait_inc, npc_ld, pc_ld;

   always_comb begin
      state_d   = state_q;
      IMEM_REQ  = 1'b0;
      DMEM_REQ  = 1'b0;
      FETCH_EN  = 1'b0;
      DECODE_EN = 1'b0;
      EXEC_EN   = 1'b0;
      WB_EN     = 1'b0;
      wait_clr  = 1'b0;
      wait_inc  = 1'b0;
      npc_ld    = 1'b0;
      pc_ld     = 1'b0;
      case (state_q)
         S_IDLE: begin
            wait_clr = 1'b1;
            if (START) state_d = S_FETCH;
         end
         // ACK in the cycle the counter sits at MEM_TIMEOUT still wins over the fault
         S_FETCH: begin
            IMEM_REQ = 1'b1;
            if (IMEM_ACK) begin
               FETCH_EN = 1'b1;
               state_d  = S_DECODE;
            end else if (wait_q == CNT_MAX) begin
               state_d = S_ERROR;
            end else begin
               wait_inc = 1'b1;
            end
         end
         S_DECODE: begin
            DECODE_EN = 1'b1;
            state_d   = S_EXECUTE;
         end
         S_EXECUTE: begin
            EXEC_EN = 1'b1;
            npc_ld  = 1'b1;
            if (IS_MEM) begin
               wait_clr = 1'b1;
               state_d  = S_MEM;
            end else begin
               state_d = S_WRITE;
            end
         end
         S_MEM: begin
            DMEM_REQ = 1'b1;
            if (DMEM_ACK) begin
               state_d = S_WRITE;
            end else if (wait_q == CNT_MAX) begin
               state_d = S_ERROR;
            end else begin
               wait_inc = 1'b1;
            end
         end
         S_WRITE: begin
            WB_EN    = 1'b1;
            pc_ld    = 1'b1;
            wait_clr = 1'b1;
            state_d  = halt_q ? S_HALT : S_FETCH;
         end
         default: ;
      endcase
   end

   assign RETIRE    = WB_EN;
   assign HALTED    = (state_q == S_HALT);
   assign FAULT     = (state_q == S_ERROR);
   assign PC        = pc_q;
   assign IMEM_ADDR = pc_q;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         halt_q  <= 1'b0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         if (pc_ld)  pc_q   <= npc_q;
         if (npc_ld) halt_q <= (NEXT_PC == pc_q);
         if (wait_clr)      wait_q <= '0;
         else if (wait_inc) wait_q <= wait_q + 1'b1;
      end
   end

   // npc_q is pure data: only read after EXECUTE has loaded it
   always_ff @(posedge CLK) begin
      if (npc_ld) npc_q <= NEXT_PC;
   end

`ifdef SEQ_PERF_CNT_EN
   logic [63:0] cycle_q, instret_q;
   logic        active;

   assign active = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR);

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if (active) cycle_q   <= cycle_q + 64'd1;
         if (WB_EN)  instret_q <= instret_q + 64'd1;
      end
   end

   assign CYCLE_CNT   = cycle_q;
   assign INSTRET_CNT = instret_q;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: driver plans instructions and pushes expected
// retire PC / latency / next PC; a negedge monitor pops and compares on RETIRE.
module tb_stage_sequencer;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic        START = 1'b0;
   logic        IMEM_REQ, DMEM_REQ;
   logic [31:0] IMEM_ADDR, PC;
   logic        IMEM_ACK = 1'b0, DMEM_ACK = 1'b0, IS_MEM = 1'b0;
   logic [31:0] NEXT_PC = '0;
   logic        FETCH_EN, DECODE_EN, EXEC_EN, WB_EN, RETIRE, HALTED, FAULT;
`ifdef SEQ_PERF_CNT_EN
   logic [63:0] CYCLE_CNT, INSTRET_CNT;
`endif

   stage_sequencer #(.XLEN(32), .RESET_PC(32'd0), .MEM_TIMEOUT(15)) dut (
      .CLK(CLK), .RSTN(RSTN), .START(START),
      .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK),
      .DMEM_REQ(DMEM_REQ), .DMEM_ACK(DMEM_ACK),
      .IS_MEM(IS_MEM), .NEXT_PC(NEXT_PC),
      .FETCH_EN(FETCH_EN), .DECODE_EN(DECODE_EN), .EXEC_EN(EXEC_EN), .WB_EN(WB_EN),
      .PC(PC), .RETIRE(RETIRE),
`ifdef SEQ_PERF_CNT_EN
      .CYCLE_CNT(CYCLE_CNT), .INSTRET_CNT(INSTRET_CNT),
`endif
      .HALTED(HALTED), .FAULT(FAULT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] npc;
      int          lat;
   } exp_t;

   exp_t        sbq[$];
   int          errors = 0;
   int          checks = 0;
   int          onehot_viol = 0;
   logic [31:0] pc_m;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: samples 2ns after each falling edge so combinational outputs have settled
   initial begin : monitor
      int          cyc, fstart;
      logic        req_prev, npc_pend;
      logic [31:0] npc_exp;
      exp_t        e;
      cyc = 0; fstart = 0; req_prev = 1'b0; npc_pend = 1'b0; npc_exp = '0;
      forever begin
         @(negedge CLK);
         #2;
         cyc++;
         if (!RSTN) begin
            npc_pend = 1'b0;
            req_prev = 1'b0;
         end else begin
            if (IMEM_REQ && !req_prev) fstart = cyc;
            if ($countones({FETCH_EN, DECODE_EN, EXEC_EN, WB_EN}) > 1) onehot_viol++;
            if (WB_EN !== RETIRE) onehot_viol++;
            if (npc_pend) begin
               check("pc_after_retire", 64'(PC), 64'(npc_exp));
               npc_pend = 1'b0;
            end
            if (RETIRE) begin
               if (sbq.size() == 0) begin
                  check("retire_unexpected", 64'd1, 64'd0);
               end else begin
                  e = sbq.pop_front();
                  check("retire_pc", 64'(PC), 64'(e.pc));
                  check("retire_latency", 64'(cyc - fstart + 1), 64'(e.lat));
                  npc_pend = 1'b1;
                  npc_exp  = e.npc;
               end
            end
            req_prev = IMEM_REQ;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic do_reset();
      RSTN = 1'b0; START = 1'b0; IMEM_ACK = 1'b0; DMEM_ACK = 1'b0; IS_MEM = 1'b0;
      repeat (2) @(negedge CLK);
      sbq.delete();
      pc_m = 32'd0;
      RSTN = 1'b1;
   endtask

   task automatic do_start();
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   // Entered at a falling edge with the DUT in FETCH; returns at the falling edge after WRITE.
   task automatic run_instr(input logic [31:0] npc, input bit is_mem, input int w, input int dw);
      exp_t e;
      e.pc  = pc_m;
      e.npc = npc;
      e.lat = (w + 1) + 2 + (is_mem ? dw + 1 : 0) + 1;
      sbq.push_back(e);
      pc_m    = npc;
      IS_MEM  = is_mem;
      NEXT_PC = npc;
      for (int k = 0; k <= w; k++) begin
         IMEM_ACK = (k == w);
         DMEM_ACK = 1'($urandom_range(0, 1));
         @(negedge CLK);
      end
      IMEM_ACK = 1'b0; DMEM_ACK = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      if (is_mem) begin
         for (int k = 0; k <= dw; k++) begin
            DMEM_ACK = (k == dw);
            IMEM_ACK = 1'($urandom_range(0, 1));
            @(negedge CLK);
         end
         IMEM_ACK = 1'b0; DMEM_ACK = 1'b0;
      end
      @(negedge CLK);
   endtask

   initial begin : driver
      logic [31:0] n;
      bit          m;
      int          w, dw;

      // Reset state
      #2;
      check("reset_pc", 64'(PC), 64'd0);
      check("reset_outputs", 64'({IMEM_REQ, DMEM_REQ, FETCH_EN, DECODE_EN, EXEC_EN, WB_EN,
                                  RETIRE, HALTED, FAULT}), 64'd0);
      do_reset();
      for (int k = 0; k < 3; k++) begin
         IMEM_ACK = 1'($urandom_range(0, 1));
         DMEM_ACK = 1'($urandom_range(0, 1));
         @(negedge CLK);
         #2;
         check("idle_no_req", 64'({IMEM_REQ, DMEM_REQ}), 64'd0);
      end
      IMEM_ACK = 1'b0; DMEM_ACK = 1'b0;

      // Four sequential instructions, the fourth jumps to itself
      do_start();
      run_instr(32'd1, 1'b0, 1, 0);
      run_instr(32'd2, 1'b0, 1, 0);
      run_instr(32'd3, 1'b0, 1, 0);
      run_instr(32'd3, 1'b0, 1, 0);
      #2;
      check("halt_flag_seq", 64'(HALTED), 64'd1);
`ifdef SEQ_PERF_CNT_EN
      check("instret_cnt", INSTRET_CNT, 64'd4);
      check("cycle_cnt", CYCLE_CNT, 64'd20);
`endif
      START = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         #2;
         check("halt_quiet", 64'({IMEM_REQ, DMEM_REQ, HALTED}), 64'd1);
      end
      START = 1'b0;
      check("halt_pc_frozen", 64'(PC), 64'd3);

      // Randomized stream with wrap, max-wait acks, and a final self-jump at 35
      do_reset();
      do_start();
      for (int i = 0; i < 40; i++) begin
         n  = pc_m + 32'd1;
         if ($urandom_range(0, 7) == 0) n = $urandom;
         if (i == 10) n = 32'hFFFF_FFFF;
         if (i == 11) n = pc_m + 32'd1;
         if (n == pc_m) n = pc_m + 32'd2;
         m  = ($urandom_range(0, 2) == 0);
         w  = $urandom_range(0, 3);
         dw = $urandom_range(0, 3);
         if (i == 0)  begin w = 1; m = 1'b1; dw = 3; end
         if (i == 20) w = 15;
         if (i == 21) begin m = 1'b1; dw = 15; end
         run_instr(n, m, w, dw);
      end
      run_instr(32'd35, 1'b1, 0, 0);
      run_instr(32'd35, 1'b0, 1, 0);
      for (int k = 0; k < 3; k++) begin
         IMEM_ACK = 1'b1;
         @(negedge CLK);
         #2;
         check("halt35", 64'({HALTED, IMEM_REQ, FAULT}), 64'b100);
      end
      IMEM_ACK = 1'b0;
      check("halt35_pc", 64'(PC), 64'd35);

      // IMEM timeout: 16 cycles without ack -> ERROR
      do_reset();
      do_start();
      run_instr(32'd1, 1'b0, 15, 0);
      for (int k = 0; k <= 15; k++) begin
         IMEM_ACK = 1'b0;
         if (k == 15) begin
            #2;
            check("imem_last_wait", 64'({IMEM_REQ, FAULT}), 64'b10);
         end
         @(negedge CLK);
      end
      #2;
      check("imem_fault", 64'({FAULT, IMEM_REQ, DMEM_REQ}), 64'b100);
      IMEM_ACK = 1'b1;
      repeat (3) @(negedge CLK);
      #2;
      check("fault_sticky_pc", 64'({FAULT, PC}), {31'd0, 1'b1, 32'd1});
      IMEM_ACK = 1'b0;

      // DMEM timeout
      do_reset();
      do_start();
      run_instr(32'd5, 1'b0, 0, 0);
      NEXT_PC = 32'd6; IS_MEM = 1'b1; IMEM_ACK = 1'b1;
      @(negedge CLK);
      IMEM_ACK = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      for (int k = 0; k <= 15; k++) begin
         if (k == 15) begin
            #2;
            check("dmem_last_wait", 64'({DMEM_REQ, FAULT}), 64'b10);
         end
         @(negedge CLK);
      end
      #2;
      check("dmem_fault", 64'({FAULT, DMEM_REQ, IMEM_REQ}), 64'b100);
      check("dmem_fault_pc", 64'(PC), 64'd5);

      // Asynchronous reset while DMEM_REQ is high
      do_reset();
      do_start();
      run_instr(32'd9, 1'b0, 0, 0);
      NEXT_PC = 32'd10; IS_MEM = 1'b1; IMEM_ACK = 1'b1;
      @(negedge CLK);
      IMEM_ACK = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      #2;
      check("mem_req_before_rst", 64'({DMEM_REQ, PC}), {31'd0, 1'b1, 32'd9});
      RSTN = 1'b0;
      #1;
      check("rst_drops_req", 64'({DMEM_REQ, IMEM_REQ}), 64'd0);
      check("rst_pc", 64'(PC), 64'd0);
      @(negedge CLK);
      RSTN = 1'b1; DMEM_ACK = 1'b1; IMEM_ACK = 1'b1;
      pc_m = 32'd0;
      @(negedge CLK);
      DMEM_ACK = 1'b0; IMEM_ACK = 1'b0;
      repeat (2) @(negedge CLK);
      #2;
      check("post_rst_idle", 64'({IMEM_REQ, DMEM_REQ, PC}), 64'd0);
      @(negedge CLK);
      do_start();
      run_instr(32'd1, 1'b0, 1, 0);
      repeat (2) @(negedge CLK);

      check("enable_onehot_violations", 64'(onehot_viol), 64'd0);
      check("scoreboard_drained", 64'(sbq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
